// File: rtl/fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arb
// Description : Round-robin burst read arbiter for four show-ahead FIFOs.
//               In IDLE a winner is chosen among channels holding at least
//               a burst of data (normal mode) or, when flush is set and no
//               channel qualifies normally, among non-empty channels
//               (single-word mode). In BURST the granted FIFO is popped
//               straight into a one-deep output register with valid/ready
//               handshake, sustaining one word per cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DSIZE - data word width
//               NCH   - number of read channels (4 in this revision)
//               BURST - words per normal burst (1..255)
// Ports       : clk        in   read clock shared with all attached FIFOs
//               rst        in   asynchronous active-high reset
//               ch_en      in   per-channel enable
//               flush      in   permit single-word drain of non-empty channels
//               ch_repty   in   FIFO empty flags
//               ch_aempty  in   FIFO almost-empty flags
//               ch_rdata   in   FIFO head data, channel i at [i*DSIZE +: DSIZE]
//               ch_rreq    out  FIFO read requests (one-hot or zero)
//               m_valid    out  output word valid
//               m_ready    in   downstream accept
//               m_data     out  output word
//               m_chan     out  source channel of m_data
//               m_last     out  final word of a burst
//               busy       out  high while a burst is in progress
// ============================================================================
module fifo_rd_arb #(
    parameter int DSIZE = 16,
    parameter int NCH   = 4,
    parameter int BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_en,
    input  logic                 flush,
    input  logic [NCH-1:0]       ch_repty,
    input  logic [NCH-1:0]       ch_aempty,
    input  logic [NCH*DSIZE-1:0] ch_rdata,
    output logic [NCH-1:0]       ch_rreq,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DSIZE-1:0]     m_data,
    output logic [1:0]           m_chan,
    output logic                 m_last,
    output logic                 busy
);

    localparam int       c_IW       = 2;
    localparam logic [7:0] c_LAST_CNT = 8'(BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_IW-1:0]   r_grant;
    logic              r_single;
    logic [7:0]        r_cnt;
    logic [c_IW-1:0]   r_rr_ptr;

    logic [NCH-1:0]    w_norm_elig;
    logic [NCH-1:0]    w_flush_elig;
    logic [NCH-1:0]    w_elig;
    logic              w_any_norm;
    logic              w_win_found;
    logic [c_IW-1:0]   w_win_idx;
    logic              w_last;
    logic              w_pop;
    logic [DSIZE-1:0]  w_rdata_arr [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign w_rdata_arr[gi] = ch_rdata[gi*DSIZE +: DSIZE];
        end
    endgenerate

    // Normal candidates take absolute priority; flush candidates are only
    // considered when no channel holds a full burst.
    assign w_norm_elig  = ch_en & ~ch_aempty;
    assign w_any_norm   = |w_norm_elig;
    assign w_flush_elig = (flush && !w_any_norm) ? (ch_en & ~ch_repty) : '0;
    assign w_elig       = w_any_norm ? w_norm_elig : w_flush_elig;

    // Round-robin search starting at r_rr_ptr; the 2-bit index wraps mod 4.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            logic [c_IW-1:0] cand;
            cand = r_rr_ptr + c_IW'(k);
            if (!w_win_found && w_elig[cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = cand;
            end
        end
    end

    assign w_last = r_single | (r_cnt == c_LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pop only happens when the output register is free or being drained
    // this cycle, and the granted FIFO actually has data.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        ch_rreq     = '0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                busy             = 1'b1;
                ch_rreq[r_grant] = ~m_valid | m_ready;
                w_pop            = (~m_valid | m_ready) & ~ch_repty[r_grant];
                if (w_pop && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant  <= '0;
            r_single <= 1'b0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_chan   <= '0;
            m_last   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_win_found) begin
                r_grant  <= w_win_idx;
                r_single <= ~w_any_norm;
                r_cnt    <= '0;
            end
            if (w_pop) begin
                m_data  <= w_rdata_arr[r_grant];
                m_chan  <= r_grant;
                m_valid <= 1'b1;
                m_last  <= w_last;
                r_cnt   <= r_cnt + 8'd1;
                if (w_last) begin
                    r_rr_ptr <= r_grant + c_IW'(1);
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_arb
// Description : Bench for fifo_rd_arb. Four show-ahead FIFOs are modelled
//               with queues; a transaction-level reference decides grants,
//               pops and output words from the arbitration rules, and every
//               cycle the DUT outputs are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arb;

    localparam int c_DSIZE = 16;
    localparam int c_NCH   = 4;
    localparam int c_BURST = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [c_NCH-1:0]         ch_en;
    logic                     flush;
    logic [c_NCH-1:0]         ch_repty;
    logic [c_NCH-1:0]         ch_aempty;
    logic [c_NCH*c_DSIZE-1:0] ch_rdata;
    logic [c_NCH-1:0]         ch_rreq;
    logic                     m_valid;
    logic                     m_ready;
    logic [c_DSIZE-1:0]       m_data;
    logic [1:0]               m_chan;
    logic                     m_last;
    logic                     busy;

    fifo_rd_arb #(
        .DSIZE (c_DSIZE),
        .NCH   (c_NCH),
        .BURST (c_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .flush     (flush),
        .ch_repty  (ch_repty),
        .ch_aempty (ch_aempty),
        .ch_rdata  (ch_rdata),
        .ch_rreq   (ch_rreq),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_chan    (m_chan),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // FIFO contents and stimulus helpers
    logic [c_DSIZE-1:0] fifo_q [c_NCH][$];
    int                 seq [c_NCH];
    logic [c_NCH-1:0]   aempty_force;   // lie "not almost-empty" to provoke stalls
    int                 pop_ch;

    // Reference model state
    int mdl_busy, mdl_g, mdl_single, mdl_n, mdl_rr;
    int mdl_v, mdl_d, mdl_c, mdl_l;

    int n_checks;
    int n_pass;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int ch);
        fifo_q[ch].push_back(c_DSIZE'((ch << 12) | (seq[ch] & 12'hfff)));
        seq[ch]++;
    endtask

    task automatic drive_flags();
        for (int i = 0; i < c_NCH; i++) begin
            ch_repty[i]  = (fifo_q[i].size() == 0);
            ch_aempty[i] = aempty_force[i] ? 1'b0 : (fifo_q[i].size() < c_BURST);
            ch_rdata[i*c_DSIZE +: c_DSIZE] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : '0;
        end
    endtask

    // Compare DUT against the reference for the current cycle, then advance
    // the reference to what the next clock edge must produce.
    task automatic model_step();
        int exp_rreq;
        int any_norm;
        int found;
        if (rst) begin
            mdl_busy = 0; mdl_g = 0; mdl_single = 0; mdl_n = 0; mdl_rr = 0;
            mdl_v = 0; mdl_d = 0; mdl_c = 0; mdl_l = 0;
        end
        exp_rreq = (mdl_busy != 0 && (mdl_v == 0 || m_ready)) ? (1 << mdl_g) : 0;
        chk("busy", 32'(busy), 32'(mdl_busy));
        chk("ch_rreq", 32'(ch_rreq), 32'(exp_rreq));
        chk("m_valid", 32'(m_valid), 32'(mdl_v));
        if (mdl_v != 0 || rst) begin
            chk("m_data", 32'(m_data), 32'(mdl_d));
            chk("m_chan", 32'(m_chan), 32'(mdl_c));
            chk("m_last", 32'(m_last), 32'(mdl_l));
        end
        pop_ch = -1;
        if (rst) return;
        if (mdl_busy == 0) begin
            any_norm = 0;
            for (int i = 0; i < c_NCH; i++)
                if (ch_en[i] && !ch_aempty[i]) any_norm = 1;
            found = 0;
            for (int k = 0; k < c_NCH; k++) begin
                int c;
                int ok;
                c  = (mdl_rr + k) % c_NCH;
                ok = any_norm ? int'(ch_en[c] && !ch_aempty[c])
                              : int'(flush && ch_en[c] && fifo_q[c].size() > 0);
                if (found == 0 && ok != 0) begin
                    found      = 1;
                    mdl_busy   = 1;
                    mdl_g      = c;
                    mdl_single = (any_norm == 0);
                    mdl_n      = 0;
                end
            end
        end else if (exp_rreq != 0 && fifo_q[mdl_g].size() > 0) begin
            pop_ch = mdl_g;
            mdl_n++;
            mdl_v = 1;
            mdl_d = int'(fifo_q[mdl_g][0]);
            mdl_c = mdl_g;
            mdl_l = (mdl_single != 0 || mdl_n == c_BURST);
            if (mdl_l != 0) begin
                mdl_busy = 0;
                mdl_rr   = (mdl_g + 1) % c_NCH;
            end
        end
        if (pop_ch < 0 && m_ready) mdl_v = 0;
    endtask

    task automatic tick();
        logic [c_DSIZE-1:0] tmp;
        drive_flags();
        #1;
        model_step();
        @(posedge clk);
        #1;
        if (pop_ch >= 0) tmp = fifo_q[pop_ch].pop_front();
        pop_ch = -1;
    endtask

    // Let any open burst finish, confirm the DUT is quiet, then empty FIFOs.
    task automatic settle();
        ch_en = '0; flush = 1'b0; m_ready = 1'b1; aempty_force = '0;
        for (int t = 0; t < 60 && (mdl_busy != 0 || mdl_v != 0); t++) tick();
        tick();
        chk("settle_busy", 32'(busy), 32'd0);
        chk("settle_valid", 32'(m_valid), 32'd0);
        for (int i = 0; i < c_NCH; i++) fifo_q[i].delete();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        pop_ch = -1;
        for (int i = 0; i < c_NCH; i++) seq[i] = 0;
        rst = 1'b1; m_ready = 1'b1; ch_en = '0; flush = 1'b0; aempty_force = '0;
        ch_repty = '1; ch_aempty = '1; ch_rdata = '0;

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single channel, continuous accept
        for (int j = 0; j < 8; j++) push(0);
        ch_en = 4'b0001;
        repeat (14) tick();
        settle();

        // Round-robin across all channels
        for (int i = 0; i < c_NCH; i++)
            for (int j = 0; j < 12; j++) push(i);
        ch_en = 4'b1111;
        repeat (30) tick();

        // Backpressure mid-burst
        repeat (2) tick();
        m_ready = 1'b0;
        repeat (5) tick();
        m_ready = 1'b1;
        repeat (10) tick();
        settle();

        // Flush: three words in ch2 below the almost-empty level
        for (int j = 0; j < 3; j++) push(2);
        ch_en = 4'b0100; flush = 1'b1;
        repeat (12) tick();
        settle();

        // Disable mid-burst: ch1 enable dropped after two words popped
        for (int j = 0; j < 4; j++) push(1);
        ch_en = 4'b0010;
        repeat (3) tick();
        ch_en = 4'b0000;
        repeat (6) tick();
        settle();

        // Empty-FIFO stall during a burst, resumed by new data
        for (int j = 0; j < 2; j++) push(3);
        aempty_force = 4'b1000; ch_en = 4'b1000;
        repeat (6) tick();
        aempty_force = '0; ch_en = '0;
        for (int j = 0; j < 2; j++) push(3);
        repeat (6) tick();
        settle();

        // Reset mid-burst: round-robin pointer returns to ch0
        for (int i = 0; i < c_NCH; i++)
            for (int j = 0; j < 8; j++) push(i);
        ch_en = 4'b1111;
        repeat (6) tick();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        settle();

        // Randomised traffic
        for (int t = 0; t < 800; t++) begin
            if (t % 40 == 0) begin
                ch_en = 4'($urandom_range(0, 15));
                flush = ($urandom_range(0, 2) == 0);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < c_NCH; i++)
                if ($urandom_range(0, 5) == 0 && fifo_q[i].size() < 24) push(i);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
